// File: rtl/jtopl_acc.sv
// -----------------------------------------------------------------------------
// jtopl_acc
//
// Per-sample output accumulator fed by the operator stage. One signed 14-bit
// operator result arrives per operator slot in the fixed slot order. Carriers
// always contribute to the frame sum; modulators contribute only when their
// channel connection is additive. On the last slot of a frame the sum is
// shifted by SHIFT, saturated to 16 bits and presented on snd with a
// one-clock sample strobe.
//
// Parameters:
//   SHIFT  left shift (0..3) applied to the frame sum before saturation
//   SLOTS  operator slots per frame; the slot counter wraps at SLOTS-1
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   cenop      operator clock enable; all frame state advances only with it
//   zero       high on the cenop cycle carrying slot 0
//   op         1 = carrier, 0 = modulator (aligned with op_result)
//   con        channel connection, 1 = additive (aligned with op_result)
//   op_result  signed operator output for the current slot
//   snd        signed saturated sample of the last complete frame
//   sample     one-clk strobe marking that snd was updated
//   ovf        sticky saturation flag, cleared only by reset
// -----------------------------------------------------------------------------
module jtopl_acc #(
    parameter int unsigned SHIFT = 1,
    parameter int unsigned SLOTS = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cenop,
    input  logic               zero,
    input  logic               op,
    input  logic               con,
    input  logic signed [13:0] op_result,
    output logic signed [15:0] snd,
    output logic               sample,
    output logic               ovf
);

    // 19 bits hold 18 x +/-8192 without internal overflow.
    localparam int unsigned AW = 19;
    localparam int unsigned TW = AW + SHIFT;
    localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic signed [TW-1:0] SAT_MAX = TW'(32767);
    localparam logic signed [TW-1:0] SAT_MIN = -TW'(32768);

    logic        [SW-1:0] slot_q;
    logic        [SW-1:0] cur;
    logic        [SW-1:0] slot_next;
    logic                 last;
    logic                 frame_valid;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] sum;
    logic signed [TW-1:0] total;
    logic signed [15:0]   sat;
    logic                 clip;

    // NOTE: every signal written in an always_comb gets an unconditional
    // value first so no path can leave it unassigned and infer a latch.
    always_comb begin
        cur       = zero ? '0 : slot_q;
        last      = (cur == SW'(SLOTS - 1));
        slot_next = last ? '0 : cur + SW'(1);

        term = '0;
        if (op || con)
            term = AW'(op_result);          // sign-extending cast

        // Slot 0 starts a fresh frame, discarding any partial sum.
        sum   = (cur == '0) ? term : acc + term;
        total = TW'(sum) <<< SHIFT;

        sat  = total[15:0];
        clip = 1'b0;
        if (total > SAT_MAX) begin
            sat  = 16'sh7fff;
            clip = 1'b1;
        end else if (total < SAT_MIN) begin
            sat  = -16'sh8000;
            clip = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q      <= '0;
            acc         <= '0;
            frame_valid <= 1'b0;
            snd         <= '0;
            sample      <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            // The strobe is a single clk wide, independent of cenop.
            sample <= 1'b0;
            if (cenop) begin
                slot_q <= slot_next;
                acc    <= sum;
                // Only a zero-aligned frame start qualifies output. A resync
                // mid-frame reloads acc, so the truncated frame never reaches
                // the last slot and is dropped without a sample.
                if (zero)
                    frame_valid <= 1'b1;
                if (last && frame_valid) begin
                    snd    <= sat;
                    ovf    <= ovf | clip;
                    sample <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtopl_acc.sv
// -----------------------------------------------------------------------------
// tb_jtopl_acc
//
// Self-checking bench for jtopl_acc. Directed frames cover the nominal sum,
// modulator gating, saturation, early resync, cenop gaps and a mid-frame
// reset; randomized frames follow. Expected values come from a frame-level
// model that keeps the audible terms of the current frame in a queue and sums
// them with plain integer arithmetic when the last slot arrives.
// -----------------------------------------------------------------------------
module tb_jtopl_acc;

    localparam int SHIFT = 1;
    localparam int SLOTS = 18;

    logic               clk;
    logic               rst;
    logic               cenop;
    logic               zero;
    logic               op;
    logic               con;
    logic signed [13:0] op_result;
    logic signed [15:0] snd;
    logic               sample;
    logic               ovf;

    jtopl_acc #(
        .SHIFT(SHIFT),
        .SLOTS(SLOTS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cenop    (cenop),
        .zero     (zero),
        .op       (op),
        .con      (con),
        .op_result(op_result),
        .snd      (snd),
        .sample   (sample),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    int m_pos;
    bit m_valid;
    int m_terms[$];
    int m_snd;
    bit m_ovf;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_reset();
        m_pos   = 0;
        m_valid = 1'b0;
        m_terms.delete();
        m_snd   = 0;
        m_ovf   = 1'b0;
    endtask

    // One cenop slot, followed by 'gaps' idle clocks with cenop low.
    task automatic drive_slot(input bit z, input bit o, input bit c,
                              input int v, input int gaps);
        bit     exp_s;
        longint total;
        @(negedge clk);
        zero      = z;
        op        = o;
        con       = c;
        op_result = 14'(v);
        cenop     = 1'b1;
        @(posedge clk);
        #1;

        if (z) begin
            m_pos   = 0;
            m_valid = 1'b1;
        end
        if (m_pos == 0)
            m_terms.delete();
        m_terms.push_back((o || c) ? v : 0);
        exp_s = 1'b0;
        if (m_pos == SLOTS - 1) begin
            if (m_valid) begin
                total = 0;
                foreach (m_terms[i]) total += m_terms[i];
                total = total * (longint'(1) << SHIFT);
                m_snd = clamp16(total);
                if (total > 32767 || total < -32768)
                    m_ovf = 1'b1;
                exp_s = 1'b1;
            end
            m_pos = 0;
        end else begin
            m_pos++;
        end

        check("sample", int'(sample), int'(exp_s));
        check("snd", int'(snd), m_snd);
        check("ovf", int'(ovf), int'(m_ovf));

        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            cenop     = 1'b0;
            zero      = 1'($urandom_range(0, 1));
            op        = 1'($urandom_range(0, 1));
            con       = 1'($urandom_range(0, 1));
            op_result = 14'($urandom);
            @(posedge clk);
            #1;
            check("gap_sample", int'(sample), 0);
            check("gap_snd", int'(snd), m_snd);
        end
        @(negedge clk);
        cenop = 1'b0;
        zero  = 1'b0;
    endtask

    // Full zero-aligned frame of constant content.
    task automatic const_frame(input bit o, input bit c, input int v, input int gaps);
        for (int s = 0; s < SLOTS; s++)
            drive_slot(s == 0, o, c, v, gaps);
    endtask

    // Alternating carrier/modulator frame: carriers carry 'vc', modulators 'vm'.
    task automatic gated_frame(input bit c, input int vc, input int vm);
        for (int s = 0; s < SLOTS; s++) begin
            bit is_car;
            is_car = (s % 2) == 1;
            drive_slot(s == 0, is_car, c, is_car ? vc : vm, 0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        cenop     = 1'b0;
        zero      = 1'b0;
        op        = 1'b0;
        con       = 1'b0;
        op_result = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_snd", int'(snd), 0);
        check("rst_sample", int'(sample), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b1;

        // Nominal frame: 18 x 100 x 2 = 3600.
        const_frame(1'b1, 1'b0, 100, 0);
        check("nominal_snd", int'(snd), 3600);

        // Modulator gating.
        gated_frame(1'b0, 10, 1000);
        check("gate_off_snd", int'(snd), 180);
        gated_frame(1'b1, 10, 1000);
        check("gate_on_snd", int'(snd), 18180);

        // Saturation, sticky ovf, negative clip.
        const_frame(1'b1, 1'b0, 8191, 0);
        check("sat_pos_snd", int'(snd), 32767);
        check("sat_pos_ovf", int'(ovf), 1);
        const_frame(1'b1, 1'b0, 0, 0);
        check("zero_frame_snd", int'(snd), 0);
        check("ovf_sticky", int'(ovf), 1);
        const_frame(1'b1, 1'b0, -8192, 0);
        check("sat_neg_snd", int'(snd), -32768);

        // Early resync at slot 7: the truncated frame yields no sample; the
        // next sample covers only the 18 slots after the second zero.
        for (int s = 0; s < 7; s++)
            drive_slot(s == 0, 1'b1, 1'b0, 500, 0);
        for (int s = 0; s < SLOTS; s++)
            drive_slot(s == 0, 1'b1, 1'b0, 20, 0);
        check("resync_snd", int'(snd), 720);

        // cenop gaps of 3 idle clocks between slots.
        const_frame(1'b1, 1'b0, 100, 3);
        check("gaps_snd", int'(snd), 3600);

        // Saturate again so the reset visibly clears ovf, then reset at slot 9.
        const_frame(1'b1, 1'b0, 8191, 0);
        for (int s = 0; s < 9; s++)
            drive_slot(s == 0, 1'b1, 1'b0, 77, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_snd", int'(snd), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_sample", int'(sample), 0);
        #1;
        rst = 1'b1;
        model_reset();

        // No zero after reset: free-running slots produce no sample.
        for (int s = 0; s < SLOTS + 4; s++)
            drive_slot(1'b0, 1'b1, 1'b0, 300, 0);
        check("no_zero_snd", int'(snd), 0);

        // Aligned frames resume normal output.
        const_frame(1'b1, 1'b0, -50, 0);
        check("resume_snd", int'(snd), -1800);

        // Randomized frames with occasional early resyncs and idle gaps.
        for (int f = 0; f < 14; f++) begin
            for (int s = 0; s < SLOTS; s++) begin
                bit z;
                z = (s == 0) || ($urandom_range(0, 39) == 0);
                drive_slot(z, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 16383)) - 8192,
                           ($urandom_range(0, 7) == 0) ? 1 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
